seq_divider4: RTL and testbench
===============================

# seq_divider4

Sequential unsigned restoring divider. It time-shares one ripple-carry add/subtract unit (mode input fixed to subtract) over WIDTH iterations to produce quotient and remainder. It is the sequencing controller that sits on top of the lab add/sub datapath and drives its operands and mode each cycle. It exposes a start/busy/done handshake to the surrounding design.

## Interface
- WIDTH, 4: operand width in bits; quotient and remainder are also WIDTH bits.
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- start  in  1  request a division; sampled only in IDLE.
- dividend  in  WIDTH  unsigned dividend; captured on the accepted start edge.
- divisor  in  WIDTH  unsigned divisor; captured on the accepted start edge.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; result valid while high.
- quotient  out  WIDTH  result quotient; held until the next accepted start.
- remainder  out  WIDTH  result remainder; held until the next accepted start.
- div_by_zero  out  1  set with done when the captured divisor was 0; held until the next accepted start.

## Operation
- States are IDLE, RUN and DONE. Reset forces IDLE.
  - Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, internal counter=0.
- IDLE with start=1:
  - Capture operands: Q←dividend, D←divisor, R←0 (R is WIDTH+1 bits), cnt←WIDTH.
  - If divisor==0, go to DONE with quotient=all ones, remainder=dividend, div_by_zero=1.
  - Otherwise clear div_by_zero and go to RUN.
- RUN performs one iteration per clk:
  - Shift: Rs={R[WIDTH-1:0],Q[WIDTH-1]}, Qs={Q[WIDTH-2:0],0}.
  - The add/sub unit computes Rs + ~{0,D} + 1 at WIDTH+1 bits.
  - Carry-out=1 (no borrow): R←difference, Q←Qs|1.
  - Carry-out=0: R←Rs, Q←Qs.
  - cnt decrements each iteration; when cnt reaches 1, go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - quotient=Q and remainder=R[WIDTH-1:0] are already registered at DONE entry.
  - Next state is IDLE unconditionally.
- start is ignored in RUN and DONE; no queuing.
- Outputs quotient, remainder and div_by_zero do not change between DONE and the next accepted start.
- Arithmetic is unsigned. R never exceeds D-1 after an iteration. The WIDTH+1-bit R prevents the shifted value from overflowing.

## Timing
- Normal division:
  - The start edge moves to RUN.
  - WIDTH RUN edges follow.
  - done is high in the cycle after the last RUN edge, which is WIDTH+1 edges after the start edge (5 for WIDTH=4).
- Divide by zero: done is high 1 edge after the start edge.
- busy rises on the start edge and falls on the edge that leaves DONE.
- Back-to-back operation: the earliest next start is accepted on the edge after done's cycle, i.e. when busy=0.
- Reset mid-operation (RUN or DONE): next edge gives IDLE with all outputs at reset values, and no done pulse.
- rst and start asserted together: reset wins.
- No combinational path from inputs to outputs; all outputs are registered.

## Structure
- Shared package `divider_pkg`:
  - state enum typedef (IDLE/RUN/DONE);
  - default WIDTH constant.
- One sub-module: `add_sub_n`.
  - Parameterized ripple-carry adder/subtractor built from full-adder cells, WIDTH+1 bits.
  - Ports: a, b, sub, sum, cout.
  - b is XORed with sub, and sub is the carry-in.
  - The controller ties sub=1.
- Controller FSM, counter and Q/R/D registers live in seq_divider4.

## Test plan
- 13/3, WIDTH=4 → done exactly 5 edges after the start edge; quotient=4, remainder=1, div_by_zero=0, busy=1 for 5 cycles.
- 15/1 and 0/5 → 15/0 and 0/0 respectively; 3/9 → quotient=0, remainder=3.
- 7/0 → done 1 edge after start; quotient=15, remainder=7, div_by_zero=1. A following 8/2 clears div_by_zero and gives quotient=4, remainder=0.
- start pulsed again during RUN with different operands → ignored; result matches the first operands, and only one done pulse occurs.
- rst asserted on the 2nd RUN edge of 14/4 → all outputs 0 next cycle, no done. A subsequent 14/4 gives quotient=3, remainder=2.
- Exhaustive sweep, all 256 dividend/divisor pairs back-to-back → each result matches dividend/divisor and dividend%divisor, or the divide-by-zero values.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and defaults for the sequential divider.
package divider_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add_sub_n.sv
// N-bit ripple-carry adder/subtractor; sub inverts b and feeds the carry-in.
module add_sub_n #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0]   c;
  logic [N-1:0] bx;

  assign c[0] = sub;
  assign bx   = b ^ {N{sub}};

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]   = a[i] ^ bx[i] ^ c[i];
    assign c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
  end

  assign cout = c[N];

endmodule

// File: rtl/seq_divider4.sv
// Sequential unsigned restoring divider: one shared subtractor, one iteration per clock.
module seq_divider4
  import divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q, d, q_nxt;
  logic [WIDTH:0]   r, rs, diff, r_nxt;
  logic [CW-1:0]    cnt;
  logic             cout;

  // Shift the next dividend bit into R; carry-out means R >= D (no borrow).
  assign rs    = {r[WIDTH-1:0], q[WIDTH-1]};
  assign q_nxt = {q[WIDTH-2:0], cout};
  assign r_nxt = cout ? diff : rs;

  add_sub_n #(.N(WIDTH + 1)) u_alu (
    .a    (rs),
    .b    ({1'b0, d}),
    .sub  (1'b1),
    .sum  (diff),
    .cout (cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (divisor == '0) ? DONE : RUN;
      RUN:  if (cnt == CW'(1)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q           <= '0;
      d           <= '0;
      r           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          q   <= dividend;
          d   <= divisor;
          r   <= '0;
          cnt <= CW'(WIDTH);
          if (divisor == '0) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end else begin
            div_by_zero <= 1'b0;
          end
        end
        RUN: begin
          q   <= q_nxt;
          r   <= r_nxt;
          cnt <= cnt - 1'b1;
          // Publish the result on the final iteration so it is valid as DONE begins.
          if (cnt == CW'(1)) begin
            quotient  <= q_nxt;
            remainder <= r_nxt[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider4.sv
// Directed bench for seq_divider4: handshake timing, corner cases and a full 4-bit sweep.
module tb_seq_divider4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [3:0] quotient, remainder;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_divider4 #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Launch one division and wait (bounded) for done; lat counts edges from the start edge.
  task automatic run_div(input logic [3:0] a, input logic [3:0] b, output int lat);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start = 1'b0;
    lat   = 1;
    while (done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, ndone;
    logic [3:0] qa, ra;

    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);

    // reset and start together: reset wins
    rst = 1'b1; start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", busy, 0);
    tick();
    chk("rst_start_idle", busy, 0);

    // 13/3 with cycle-accurate handshake checks
    dividend = 4'd13; divisor = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("13_3_busy0", busy, 1);
    chk("13_3_done0", done, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("13_3_busy_run", busy, 1);
      chk("13_3_done_run", done, 0);
    end
    tick();
    chk("13_3_done", done, 1);
    chk("13_3_busy_done", busy, 1);
    chk("13_3_q", quotient, 4);
    chk("13_3_r", remainder, 1);
    chk("13_3_dbz", div_by_zero, 0);
    tick();
    chk("13_3_done_drop", done, 0);
    chk("13_3_busy_drop", busy, 0);
    chk("13_3_q_hold", quotient, 4);
    chk("13_3_r_hold", remainder, 1);

    run_div(4'd15, 4'd1, lat);
    chk("15_1_lat", lat, 5);
    chk("15_1_q", quotient, 15);
    chk("15_1_r", remainder, 0);
    tick();
    run_div(4'd0, 4'd5, lat);
    chk("0_5_q", quotient, 0);
    chk("0_5_r", remainder, 0);
    tick();
    run_div(4'd3, 4'd9, lat);
    chk("3_9_q", quotient, 0);
    chk("3_9_r", remainder, 3);
    tick();

    run_div(4'd7, 4'd0, lat);
    chk("7_0_lat", lat, 1);
    chk("7_0_q", quotient, 15);
    chk("7_0_r", remainder, 7);
    chk("7_0_dbz", div_by_zero, 1);
    tick();
    chk("7_0_dbz_hold", div_by_zero, 1);
    chk("7_0_busy_drop", busy, 0);
    run_div(4'd8, 4'd2, lat);
    chk("8_2_lat", lat, 5);
    chk("8_2_q", quotient, 4);
    chk("8_2_r", remainder, 0);
    chk("8_2_dbz", div_by_zero, 0);
    tick();

    // second start during RUN must be ignored
    dividend = 4'd9; divisor = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    dividend = 4'd15; divisor = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0; qa = '0; ra = '0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) begin
        ndone++;
        qa = quotient;
        ra = remainder;
      end
      tick();
    end
    chk("ign_ndone", ndone, 1);
    chk("ign_q", qa, 4);
    chk("ign_r", ra, 1);
    chk("ign_idle", busy, 0);

    // reset on the second RUN edge of 14/4
    dividend = 4'd14; divisor = 4'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_q", quotient, 0);
    chk("mid_rst_r", remainder, 0);
    chk("mid_rst_dbz", div_by_zero, 0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    chk("mid_rst_no_done", ndone, 0);
    run_div(4'd14, 4'd4, lat);
    chk("14_4_q", quotient, 3);
    chk("14_4_r", remainder, 2);
    tick();

    // full sweep, each start issued as soon as busy is low
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_div(4'(a), 4'(b), lat);
        chk("sweep_done", done, 1);
        if (b == 0) begin
          chk("sweep_q", quotient, 15);
          chk("sweep_r", remainder, a);
          chk("sweep_dbz", div_by_zero, 1);
        end else begin
          chk("sweep_q", quotient, a / b);
          chk("sweep_r", remainder, a % b);
          chk("sweep_dbz", div_by_zero, 0);
        end
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
